// File: rtl/svm_dot_sequencer.sv
// rtl/svm_dot_sequencer.sv - sign-magnitude dot-product sequencer around a pipelined multiplier
// Optional result saturation with overflow flag: define SVM_ACC_SAT_EN.
module svm_dot_sequencer #(
  parameter int MUL_LAT = 10,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              svm_enable,
  input  logic              go,
  input  logic [ADDR_W-1:0] vec_len,
  input  logic [31:0]       bias,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [16:0]       x_data,
  input  logic [16:0]       w_data,
  output logic [16:0]       mul_a,
  output logic [16:0]       mul_b,
  output logic              mul_start,
  input  logic [31:0]       mul_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [16:0]       NEG_ZERO = 17'h10000;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [MUL_LAT:0]  vld_q, vld_d;
  logic [39:0]       acc_q, acc_d;
  logic [31:0]       result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              stall_q, stall_d;
  logic [16:0]       x_hold_q, x_hold_d;
  logic [16:0]       w_hold_q, w_hold_d;

  logic              acc_en;
  logic [16:0]       op_x, op_w;
  logic [32:0]       sat_res;

`ifdef SVM_ACC_SAT_EN
  function automatic logic [32:0] clamp40(input logic [39:0] a);
    if (a[39:31] == 9'h000 || a[39:31] == 9'h1FF) begin
      return {1'b0, a[31:0]};
    end else if (a[39]) begin
      return {1'b1, 32'h8000_0000};
    end else begin
      return {1'b1, 32'h7FFF_FFFF};
    end
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    stall_d  = ~svm_enable;
    x_hold_d = x_hold_q;
    w_hold_d = w_hold_q;

    mul_start = svm_enable &&
                ((state_q == S_FETCH && vld_q[0]) || state_q == S_DRAIN);
    acc_en    = mul_start && vld_q[MUL_LAT];

    // The memory keeps following the frozen address during a stall, so the
    // operand pending at stall entry is parked here and replayed on resume.
    if (!svm_enable && !stall_q) begin
      x_hold_d = x_data;
      w_hold_d = w_data;
    end
    op_x = stall_q ? x_hold_q : x_data;
    op_w = stall_q ? w_hold_q : w_data;

    mul_a = (mul_start && vld_q[0] && op_x != NEG_ZERO) ? op_x : 17'h0;
    mul_b = (mul_start && vld_q[0] && op_w != NEG_ZERO) ? op_w : 17'h0;

    if (acc_en) begin
      acc_d = acc_q + {{8{mul_data[31]}}, mul_data};
      cnt_d = cnt_q + ADDR_ONE;
    end

`ifdef SVM_ACC_SAT_EN
    sat_res = clamp40(acc_d);
`else
    sat_res = {1'b0, acc_d[31:0]};
`endif

    if (svm_enable) begin
      vld_d[0] = (state_q == S_FETCH);
      if (mul_start) begin
        for (int i = 1; i <= MUL_LAT; i++) begin
          vld_d[i] = vld_q[i-1];
        end
      end

      case (state_q)
        S_IDLE: begin
          if (go) begin
            state_d = S_FETCH;
            n_d     = (vec_len == '0) ? ADDR_ONE : vec_len;
            addr_d  = '0;
            cnt_d   = '0;
            acc_d   = {{8{bias[31]}}, bias};
          end
        end
        S_FETCH: begin
          if (addr_q == n_q - ADDR_ONE) begin
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
        S_DRAIN: begin
          if (acc_en && cnt_q == n_q - ADDR_ONE) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = sat_res[31:0];
            ovf_d    = sat_res[32];
          end
        end
        default: begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      stall_q  <= 1'b0;
      x_hold_q <= '0;
      w_hold_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      stall_q  <= stall_d;
      x_hold_q <= x_hold_d;
      w_hold_q <= w_hold_d;
    end
  end

  assign mem_addr = addr_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_svm_dot_sequencer.sv
// tb/tb_svm_dot_sequencer.sv - randomized self-checking bench for svm_dot_sequencer
module tb_svm_dot_sequencer;
  localparam int MUL_LAT = 10;
  localparam int ADDR_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              svm_enable = 1'b0;
  logic              go = 1'b0;
  logic [ADDR_W-1:0] vec_len = '0;
  logic [31:0]       bias = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [16:0]       x_data = '0;
  logic [16:0]       w_data = '0;
  logic [16:0]       mul_a, mul_b;
  logic              mul_start;
  logic [31:0]       mul_data = '0;
  logic              busy, done;
  logic [31:0]       result;
  logic              ovf;

  svm_dot_sequencer #(.MUL_LAT(MUL_LAT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .svm_enable(svm_enable), .go(go),
    .vec_len(vec_len), .bias(bias), .mem_addr(mem_addr),
    .x_data(x_data), .w_data(w_data), .mul_a(mul_a), .mul_b(mul_b),
    .mul_start(mul_start), .mul_data(mul_data), .busy(busy), .done(done),
    .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [16:0]       xmem [256];
  logic [16:0]       wmem [256];
  logic [31:0]       mpipe [MUL_LAT];
  logic [ADDR_W-1:0] mem_a_s;

  bit          chk_en = 0;
  bit          job_active = 0;
  int          job_go_edge = 0, exp_done_edge = 0;
  int          ms_cnt = 0, ms_final = 0, done_seen_edge = 0;
  logic [31:0] exp_result = '0, last_result = '0, got_result = '0;
  logic        exp_ovf = 0, last_ovf = 0, got_ovf = 0;
  int          cmp_nxt;
  bit          cmp_eb, cmp_ed;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic longint sm_val(input logic [16:0] v);
    return v[16] ? -longint'(v[15:0]) : longint'(v[15:0]);
  endfunction

  function automatic longint sx32(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  // Operand memory: data for the address seen at an edge appears just after it.
  always @(posedge clk) begin
    mem_a_s = mem_addr;
    #1;
    x_data = xmem[mem_a_s];
    w_data = wmem[mem_a_s];
  end

  // Multiplier: sign-magnitude in, two's complement out, MUL_LAT run-enabled stages.
  always @(posedge clk) begin
    if (mul_start) begin
      for (int i = MUL_LAT - 1; i > 0; i--) mpipe[i] = mpipe[i-1];
      mpipe[0] = 32'(sm_val(mul_a) * sm_val(mul_b));
    end
    #1;
    mul_data = mpipe[MUL_LAT-1];
  end

  // Cycle-by-cycle compare against the job-level model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_nxt = cyc + 1;
      if (job_active && !svm_enable && cyc >= job_go_edge) exp_done_edge++;
      cmp_eb = job_active && cyc >= job_go_edge && cmp_nxt <= exp_done_edge;
      cmp_ed = job_active && cmp_nxt == exp_done_edge;
      check("busy", 32'(busy), 32'(cmp_eb));
      check("done", 32'(done), 32'(cmp_ed));
      if (!cmp_eb || !svm_enable) check("mul_start_off", 32'(mul_start), 32'd0);
      if (!mul_start) begin
        check("mul_a_zero", 32'(mul_a), 32'd0);
        check("mul_b_zero", 32'(mul_b), 32'd0);
      end
      if (mul_start) ms_cnt++;
      if (cmp_ed) begin
        check("result", result, exp_result);
        check("ovf", 32'(ovf), 32'(exp_ovf));
        got_result     = result;
        got_ovf        = ovf;
        done_seen_edge = cmp_nxt;
        ms_final       = ms_cnt;
        last_result    = exp_result;
        last_ovf       = exp_ovf;
        job_active     = 0;
      end else begin
        check("result_hold", result, last_result);
        check("ovf_hold", 32'(ovf), 32'(last_ovf));
      end
    end
  end

  task automatic launch(input int n, input logic [31:0] b);
    int     ne;
    longint acc;
    ne  = (n == 0) ? 1 : n;
    acc = sx32(b);
    for (int i = 0; i < ne; i++) acc += sx32(32'(sm_val(xmem[i]) * sm_val(wmem[i])));
`ifdef SVM_ACC_SAT_EN
    if (acc > longint'(32'h7FFF_FFFF)) begin
      exp_result = 32'h7FFF_FFFF; exp_ovf = 1;
    end else if (acc < -longint'(32'h8000_0000)) begin
      exp_result = 32'h8000_0000; exp_ovf = 1;
    end else begin
      exp_result = acc[31:0]; exp_ovf = 0;
    end
`else
    exp_result = acc[31:0];
    exp_ovf    = 0;
`endif
    svm_enable    = 1;
    vec_len       = ADDR_W'(n);
    bias          = b;
    go            = 1;
    job_go_edge   = cyc + 1;
    exp_done_edge = cyc + 1 + ne + MUL_LAT + 2;
    ms_cnt        = 0;
    job_active    = 1;
    @(posedge clk);
    #1;
    go = 0;
  endtask

  task automatic wait_job(input int ne, input int stall_pct, input int stall_at,
                          input int stall_len, input bit spur_go);
    int en_cycles = 0;
    int stalled   = 0;
    int guard     = 0;
    while (job_active && guard < 3000) begin
      go = 0;
      if (stall_at >= 0 && en_cycles == stall_at && stalled < stall_len) begin
        svm_enable = 0;
        stalled++;
      end else if (stall_pct > 0 && en_cycles <= ne + MUL_LAT &&
                   int'($urandom_range(99)) < stall_pct) begin
        svm_enable = 0;
      end else begin
        svm_enable = 1;
        en_cycles++;
        if (spur_go && (en_cycles == 2 || en_cycles == ne + 3)) begin
          go      = 1;
          vec_len = 8'd7;
        end
      end
      @(posedge clk);
      #1;
      guard++;
    end
    go         = 0;
    svm_enable = 1;
    check("job_timeout", 32'(job_active), 32'd0);
    job_active = 0;
  endtask

  task automatic set_op(input int i, input logic [16:0] x, input logic [16:0] w);
    xmem[i] = x;
    wmem[i] = w;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mul_a"}, 32'(mul_a), 32'd0);
    check({tag, "_mul_b"}, 32'(mul_b), 32'd0);
    check({tag, "_mul_start"}, 32'(mul_start), 32'd0);
  endtask

  logic [31:0] r0;
  int          n_rand;
  logic [16:0] xr, wr;

  initial begin
    for (int i = 0; i < 256; i++) begin xmem[i] = '0; wmem[i] = '0; end
    for (int i = 0; i < MUL_LAT; i++) mpipe[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n      = 1;
    svm_enable = 1;
    chk_en     = 1;
    @(posedge clk);
    #1;

    // Single element: 3*4.
    set_op(0, 17'h00003, 17'h00004);
    launch(1, 32'd0);
    check("model_req022", exp_result, 32'd12);
    wait_job(1, 0, -1, 0, 0);
    check("single_result", got_result, 32'd12);
    check("single_latency", 32'(done_seen_edge - job_go_edge), 32'd13);
    check("single_mul_start_cycles", 32'(ms_final), 32'd11);

    // Mixed signs and a negative zero.
    set_op(0, 17'h00002, 17'h00003);
    set_op(1, 17'h10005, 17'h00007);
    set_op(2, 17'h00001, 17'h10000);
    launch(3, 32'd100);
    check("model_req023", exp_result, 32'd71);
    wait_job(3, 0, -1, 0, 0);
    check("mixed_result", got_result, 32'd71);
    check("mixed_ovf", 32'(got_ovf), 32'd0);
    check("mixed_mul_start_cycles", 32'(ms_final), 32'd13);

    // Accumulator past the 32-bit range.
    set_op(0, 17'h00100, 17'h00100);
    launch(1, 32'h7FFF_FFF0);
    wait_job(1, 0, -1, 0, 0);
`ifdef SVM_ACC_SAT_EN
    check("sat_result", got_result, 32'h7FFF_FFFF);
    check("sat_ovf", 32'(got_ovf), 32'd1);
`else
    check("wrap_result", got_result, 32'h8000_FFF0);
    check("wrap_ovf", 32'(got_ovf), 32'd0);
`endif

    // Four elements, clean run then stalled run with ignored go pulses.
    for (int i = 0; i < 4; i++)
      set_op(i, {1'(i & 1), 16'($urandom_range(1000))}, 17'($urandom_range(1000)));
    launch(4, 32'd5);
    wait_job(4, 0, -1, 0, 0);
    r0 = got_result;
    launch(4, 32'd5);
    wait_job(4, 0, 7, 5, 1);
    check("stall_same_result", got_result, r0);
    check("stall_latency", 32'(done_seen_edge - job_go_edge), 32'd21);
    check("stall_mul_start_cycles", 32'(ms_final), 32'd14);

    // Reset in the middle of FETCH, then a fresh two-element job.
    for (int i = 0; i < 5; i++) set_op(i, 17'h00050, 17'h00060);
    launch(5, 32'd1000);
    @(posedge clk);
    #1;
    rst_n       = 0;
    job_active  = 0;
    last_result = '0;
    last_ovf    = 0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    set_op(0, 17'h00005, 17'h00007);
    set_op(1, 17'h00006, 17'h10002);
    launch(2, 32'd10);
    wait_job(2, 0, -1, 0, 0);
    check("post_reset_result", got_result, 32'd33);

    // Randomized jobs with random stalls.
    for (int j = 0; j < 24; j++) begin
      n_rand = int'($urandom_range(12));
      for (int i = 0; i < 13; i++) begin
        xr = {1'($urandom_range(1)), 1'b0, 15'($urandom)};
        wr = {1'($urandom_range(1)), 1'b0, 15'($urandom)};
        if ($urandom_range(7) == 0) xr = 17'h10000;
        if ($urandom_range(7) == 0) wr = 17'h10000;
        set_op(i, xr, wr);
      end
      launch(n_rand, 32'($urandom));
      wait_job((n_rand == 0) ? 1 : n_rand, 20, -1, 0, 0);
      check("rand_mul_start_cycles", 32'(ms_final),
            32'(((n_rand == 0) ? 1 : n_rand) + MUL_LAT));
    end

    repeat (4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/svm_dot_sequencer.md
SVM_DOT_SEQUENCER -- requirements
Module: svm_dot_sequencer

Interface
REQ-001 SHALL have parameter MUL_LAT, default 10, meaning the multiplier latency in cycles from mul_a/mul_b presentation with mul_start high to the product appearing on mul_data.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the operand memory address width.
REQ-003 SHALL have ports (name, direction, width, meaning), one per line:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- svm_enable  in  1  global enable; low freezes all state.
- go  in  1  single-cycle job request.
- vec_len  in  ADDR_W  number of element pairs; 0 is treated as 1.
- bias  in  32  signed initial accumulator value.
- mem_addr  out  ADDR_W  operand read address.
- x_data  in  17  sign-magnitude operand x; returned one cycle after mem_addr.
- w_data  in  17  sign-magnitude operand w; returned one cycle after mem_addr.
- mul_a  out  17  multiplier operand a.
- mul_b  out  17  multiplier operand b.
- mul_start  out  1  multiplier run enable.
- mul_data  in  32  two's-complement product.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- result  out  32  signed dot product plus bias.
- ovf  out  1  saturation occurred.

Function
REQ-004 SHALL implement the states IDLE, FETCH, DRAIN and DONE.
REQ-005 IDLE: SHALL move to FETCH on go=1, load the accumulator with sign-extended bias, latch vec_len, and set mem_addr=0.
REQ-006 FETCH: SHALL increment mem_addr once per cycle through N-1, then move to DRAIN.
REQ-007 SHALL drive mul_a/mul_b from x_data/w_data during the cycle after each address issue, and SHALL drive them to 0 at all other times.
REQ-008 mul_start SHALL be high from the first operand cycle until DRAIN exits, continuously, with no gaps; it SHALL be low in IDLE and DONE, which guarantees at least one low cycle between jobs.
REQ-009 SHALL track operand validity with a (MUL_LAT+1)-deep valid shift register that advances only while mul_start is high.
REQ-010 SHALL add mul_data, sign-extended to a 40-bit accumulator, to the accumulator only in cycles where the valid bit emerging from the shift register is set.
REQ-011 DRAIN: SHALL move to DONE after the Nth accumulate.
REQ-012 DONE: SHALL assert done for exactly one cycle, update result/ovf, and return to IDLE.
REQ-013 Latency: done SHALL be high N+MUL_LAT+2 cycles after the edge that sampled go.
REQ-014 busy SHALL be high in FETCH, DRAIN and DONE, and low in IDLE.
REQ-015 go SHALL be ignored when not in IDLE.
REQ-016 result and ovf SHALL hold their values until the next DONE.
REQ-017 When svm_enable=0, all registers SHALL hold and mul_start SHALL be forced low; the valid pipeline therefore also stalls, and the job resumes correctly when svm_enable returns to 1.
REQ-018 A sign-magnitude -0 (0x10000) operand SHALL contribute 0 to the sum.

Reset
REQ-019 rst_n low SHALL force, at any time including mid-job:
- state to IDLE
- valid shift register and accumulator to 0
- mem_addr, mul_a, mul_b and result to 0
- mul_start, busy, done and ovf to 0

Configuration
REQ-020 Macro SVM_ACC_SAT_EN, when defined: result SHALL saturate the 40-bit accumulator to the range -2^31..2^31-1, and ovf=1 when clamping occurs.
REQ-021 When SVM_ACC_SAT_EN is not defined: result SHALL be accumulator[31:0] (wrap-around), and ovf SHALL be constant 0.

Verification
REQ-022 vec_len=1, x=0x00003, w=0x00004, bias=0 -> result=12, done exactly 13 cycles after the go edge, mul_start high 11 cycles.
REQ-023 vec_len=3, x={+2,-5 (0x10005),+1}, w={+3,+7,0x10000}, bias=100 -> result=71, ovf=0.
REQ-024 bias=0x7FFFFFF0, vec_len=1, x=w=+256 -> with SVM_ACC_SAT_EN result=0x7FFFFFFF and ovf=1; without the macro result=0x8000FFF0 and ovf=0.
REQ-025 vec_len=4 job; pull svm_enable low for 5 cycles during DRAIN -> result unchanged from the no-stall run, done delayed by 5 cycles; go pulses issued while busy=1 are ignored.
REQ-026 Assert rst_n low mid-FETCH -> all outputs return to 0 and state is IDLE; a following vec_len=2 job returns the correct sum with no residue from the aborted job.
